// File: rtl/galaxian_dl_pkg.sv
// Shared types and address map for the Galaxian ROM download path.
package galaxian_dl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_HOLD,
      ST_RUN
   } dl_state_t;

   typedef struct packed {
      logic cpu;
      logic gfx;
      logic prom;
   } region_t;

   localparam logic [15:0] CPU_BASE   = 16'h0000;
   localparam logic [15:0] GFX_BASE   = 16'h4000;
   localparam logic [15:0] PROM_BASE  = 16'h5000;
   localparam logic [15:0] PROM_END   = 16'h5020;

   localparam logic [15:0] DEFAULT_EXPECT_LEN = 16'h5020;

endpackage

// File: rtl/dl_region_decode.sv
// Combinational ioctl address decode into ROM region, region-relative address and range flag.
module dl_region_decode
   import galaxian_dl_pkg::*;
(
   input  logic [15:0] addr,
   output region_t     region,
   output logic [13:0] rel_addr,
   output logic        out_of_range
);

   always_comb begin
      region       = '0;
      rel_addr     = addr[13:0];
      out_of_range = 1'b0;
      // All bases sit on 16 KiB-aligned boundaries except the PROM, so the low 14 bits suffice.
      if (addr < GFX_BASE) begin
         region.cpu = 1'b1;
         rel_addr   = addr[13:0] - CPU_BASE[13:0];
      end else if (addr < PROM_BASE) begin
         region.gfx = 1'b1;
         rel_addr   = addr[13:0] - GFX_BASE[13:0];
      end else if (addr < PROM_END) begin
         region.prom = 1'b1;
         rel_addr    = addr[13:0] - PROM_BASE[13:0];
      end else begin
         out_of_range = 1'b1;
      end
   end

endmodule

// File: rtl/galaxian_dl_ctrl.sv
// ROM download sequencer: routes ioctl bytes to core ROMs, validates the load and owns core reset.
module galaxian_dl_ctrl
   import galaxian_dl_pkg::*;
#(
   parameter logic [15:0] EXPECT_LEN  = DEFAULT_EXPECT_LEN,
   parameter int unsigned HOLD_CYCLES = 1024
)(
   input  logic        clk_sys,
   input  logic        I_RESET_n,
   input  logic        soft_reset,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [15:0] dl_addr,
   input  logic [7:0]  dl_data,
   output logic        cpu_rom_we,
   output logic        gfx_rom_we,
   output logic        prom_we,
   output logic [13:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        core_reset,
   output logic        dl_done,
   output logic        dl_error,
   output logic [15:0] byte_count,
   output logic [7:0]  checksum
);

   localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES);

   dl_state_t   state;
   logic        dl_active_q;
   logic        range_flag;
   logic        from_dl;
   logic [15:0] hold_cnt;

   region_t     region;
   logic [13:0] rel_addr;
   logic        out_of_range;

   logic        rise;
   logic        fall;
   logic        accept;
   logic [15:0] cnt_base;
   logic [7:0]  sum_base;

   dl_region_decode u_decode (
      .addr         (dl_addr),
      .region       (region),
      .rel_addr     (rel_addr),
      .out_of_range (out_of_range)
   );

   // A byte arriving in the same cycle as the rising edge belongs to the new load.
   always_comb begin
      rise     = dl_active & ~dl_active_q;
      fall     = ~dl_active & dl_active_q;
      accept   = dl_wr & dl_active & ((state == ST_LOAD) | rise);
      cnt_base = rise ? '0 : byte_count;
      sum_base = rise ? '0 : checksum;
   end

   always_ff @(posedge clk_sys or negedge I_RESET_n) begin
      if (!I_RESET_n) begin
         state       <= ST_IDLE;
         dl_active_q <= 1'b0;
         range_flag  <= 1'b0;
         from_dl     <= 1'b0;
         hold_cnt    <= '0;
         cpu_rom_we  <= 1'b0;
         gfx_rom_we  <= 1'b0;
         prom_we     <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         core_reset  <= 1'b1;
         dl_done     <= 1'b0;
         dl_error    <= 1'b0;
         byte_count  <= '0;
         checksum    <= '0;
      end else begin
         dl_active_q <= dl_active;
         cpu_rom_we  <= 1'b0;
         gfx_rom_we  <= 1'b0;
         prom_we     <= 1'b0;
         dl_done     <= 1'b0;

         if (rise) begin
            state      <= ST_LOAD;
            core_reset <= 1'b1;
            dl_error   <= 1'b0;
            range_flag <= 1'b0;
            from_dl    <= 1'b1;
            byte_count <= '0;
            checksum   <= '0;
         end else begin
            unique case (state)
               ST_IDLE: core_reset <= 1'b1;
               ST_LOAD: if (fall) state <= ST_CHECK;
               ST_CHECK: begin
                  dl_error <= range_flag | (byte_count != EXPECT_LEN);
                  state    <= ST_HOLD;
                  hold_cnt <= 16'd1;
               end
               ST_HOLD: begin
                  core_reset <= 1'b1;
                  // Soft reset held high keeps re-arming; the full settle time runs after release.
                  if (soft_reset) begin
                     hold_cnt <= '0;
                  end else if (hold_cnt == HOLD_LAST) begin
                     state      <= dl_error ? ST_IDLE : ST_RUN;
                     core_reset <= dl_error;
                     dl_done    <= from_dl;
                     from_dl    <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt + 16'd1;
                  end
               end
               ST_RUN: begin
                  if (soft_reset) begin
                     state      <= ST_HOLD;
                     hold_cnt   <= '0;
                     core_reset <= 1'b1;
                     from_dl    <= 1'b0;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end

         if (accept) begin
            byte_count <= (cnt_base == 16'hFFFF) ? cnt_base : cnt_base + 16'd1;
            checksum   <= sum_base + dl_data;
            wr_data    <= dl_data;
            wr_addr    <= rel_addr;
            cpu_rom_we <= region.cpu;
            gfx_rom_we <= region.gfx;
            prom_we    <= region.prom;
            if (out_of_range) range_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_galaxian_dl_ctrl.sv
// Directed self-checking bench for galaxian_dl_ctrl.
module tb_galaxian_dl_ctrl;

   localparam int unsigned H = 128;

   logic        clk_sys = 1'b0;
   logic        I_RESET_n = 1'b0;
   logic        soft_reset = 1'b0;
   logic        dl_active = 1'b0;
   logic        dl_wr = 1'b0;
   logic [15:0] dl_addr = '0;
   logic [7:0]  dl_data = '0;
   logic        cpu_rom_we, gfx_rom_we, prom_we;
   logic [13:0] wr_addr;
   logic [7:0]  wr_data;
   logic        core_reset, dl_done, dl_error;
   logic [15:0] byte_count;
   logic [7:0]  checksum;

   int errors = 0;
   int checks = 0;
   int n_cpu, n_gfx, n_prom;

   galaxian_dl_ctrl #(.EXPECT_LEN(16'h5020), .HOLD_CYCLES(H)) dut (
      .clk_sys    (clk_sys),
      .I_RESET_n  (I_RESET_n),
      .soft_reset (soft_reset),
      .dl_active  (dl_active),
      .dl_wr      (dl_wr),
      .dl_addr    (dl_addr),
      .dl_data    (dl_data),
      .cpu_rom_we (cpu_rom_we),
      .gfx_rom_we (gfx_rom_we),
      .prom_we    (prom_we),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .core_reset (core_reset),
      .dl_done    (dl_done),
      .dl_error   (dl_error),
      .byte_count (byte_count),
      .checksum   (checksum)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_reset();
      #20;
      checks++;
      if ({cpu_rom_we, gfx_rom_we, prom_we, core_reset, dl_done, dl_error} !== 6'b000100 ||
          wr_addr !== 14'd0 || wr_data !== 8'd0 || byte_count !== 16'd0 || checksum !== 8'd0) begin
         errors++;
         $display("FAIL reset_values: got we=%b%b%b rst=%b done=%b err=%b addr=%h data=%h cnt=%h sum=%h, want 000 1 0 0 zeros",
                  cpu_rom_we, gfx_rom_we, prom_we, core_reset, dl_done, dl_error, wr_addr, wr_data, byte_count, checksum);
      end
      @(negedge clk_sys);
      I_RESET_n = 1'b1;
      repeat (5) tick();
      checks++;
      if (core_reset !== 1'b1) begin
         errors++;
         $display("FAIL idle_core_reset: got %b want 1", core_reset);
      end
   endtask

   // Streams n bytes (data = addr[7:0]); index oor_at is redirected to 0x6000.
   // Leaves the bench in the CHECK cycle after dl_active has dropped.
   task automatic do_load(input int n, input int oor_at, input bit wr_on_fall);
      logic [15:0] a;
      logic [15:0] off;
      logic [7:0]  sum_model;
      logic        e_cpu, e_gfx, e_prom;
      int          bad;
      bad = 0; n_cpu = 0; n_gfx = 0; n_prom = 0; sum_model = '0;
      dl_active = 1'b1;
      tick();
      for (int i = 0; i < n; i++) begin
         a = (i == oor_at) ? 16'h6000 : 16'(i);
         dl_wr = 1'b1; dl_addr = a; dl_data = a[7:0];
         sum_model = sum_model + a[7:0];
         tick();
         e_cpu  = (a < 16'h4000);
         e_gfx  = (a >= 16'h4000) && (a < 16'h5000);
         e_prom = (a >= 16'h5000) && (a < 16'h5020);
         off    = e_cpu ? a : (e_gfx ? a - 16'h4000 : a - 16'h5000);
         if ({cpu_rom_we, gfx_rom_we, prom_we} !== {e_cpu, e_gfx, e_prom}) bad++;
         else if ((e_cpu | e_gfx | e_prom) && (wr_addr !== off[13:0] || wr_data !== a[7:0])) bad++;
         if (cpu_rom_we) n_cpu++;
         if (gfx_rom_we) n_gfx++;
         if (prom_we)    n_prom++;
      end
      dl_wr = wr_on_fall; dl_active = 1'b0; dl_addr = 16'h5000; dl_data = 8'hAA;
      tick();
      dl_wr = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL decode: %0d bytes with wrong strobe/addr/data, want 0", bad);
      end
      checks++;
      if ({cpu_rom_we, gfx_rom_we, prom_we} !== 3'b000) begin
         errors++;
         $display("FAIL fall_cycle_strobe: got %b want 000", {cpu_rom_we, gfx_rom_we, prom_we});
      end
      checks++;
      if (byte_count !== 16'(n)) begin
         errors++;
         $display("FAIL byte_count: got %h want %h", byte_count, 16'(n));
      end
      checks++;
      if (checksum !== sum_model) begin
         errors++;
         $display("FAIL checksum: got %h want %h", checksum, sum_model);
      end
   endtask

   // From the CHECK cycle, expects dl_done exactly H+1 cycles later.
   task automatic wait_hold(input bit exp_err, input string tag);
      int t;
      int glitch;
      t = 0; glitch = 0;
      while (t < 4 * int'(H)) begin
         tick();
         t++;
         if (dl_done) break;
         if (core_reset !== 1'b1) glitch++;
      end
      checks++;
      if (t !== int'(H) + 1 || dl_done !== 1'b1) begin
         errors++;
         $display("FAIL %s_done_time: done=%b after %0d cycles, want 1 after %0d", tag, dl_done, t, H + 1);
      end
      checks++;
      if (glitch !== 0) begin
         errors++;
         $display("FAIL %s_reset_glitch: core_reset low %0d times during hold, want 0", tag, glitch);
      end
      checks++;
      if (core_reset !== exp_err || dl_error !== exp_err) begin
         errors++;
         $display("FAIL %s_exit: core_reset=%b dl_error=%b, want %b %b", tag, core_reset, dl_error, exp_err, exp_err);
      end
      tick();
      checks++;
      if (dl_done !== 1'b0) begin
         errors++;
         $display("FAIL %s_done_pulse: dl_done still %b, want 0", tag, dl_done);
      end
   endtask

   task automatic test_short_load();
      do_load(16'h5000, -1, 1'b0);
      wait_hold(1'b1, "short");
      repeat (20) tick();
      checks++;
      if (core_reset !== 1'b1) begin
         errors++;
         $display("FAIL short_idle: core_reset=%b want 1", core_reset);
      end
   endtask

   task automatic test_out_of_range_and_restart();
      do_load(16'h5020, 16'h501F, 1'b0);
      checks++;
      if (n_prom !== 16'h1F || n_cpu !== 16'h4000 || n_gfx !== 16'h1000) begin
         errors++;
         $display("FAIL oor_strobe_counts: cpu=%h gfx=%h prom=%h, want 4000 1000 1f", n_cpu, n_gfx, n_prom);
      end
      tick();
      checks++;
      if (dl_error !== 1'b1 || core_reset !== 1'b1) begin
         errors++;
         $display("FAIL oor_error: dl_error=%b core_reset=%b, want 1 1", dl_error, core_reset);
      end
      repeat (99) tick();
      dl_active = 1'b1;
      tick();
      checks++;
      if (byte_count !== 16'd0 || checksum !== 8'd0 || dl_error !== 1'b0 || core_reset !== 1'b1 || dl_done !== 1'b0) begin
         errors++;
         $display("FAIL restart_clear: cnt=%h sum=%h err=%b rst=%b done=%b, want 0 0 0 1 0",
                  byte_count, checksum, dl_error, core_reset, dl_done);
      end
      do_load(16'h5020, -1, 1'b1);
      checks++;
      if (n_cpu !== 16'h4000 || n_gfx !== 16'h1000 || n_prom !== 16'h20) begin
         errors++;
         $display("FAIL clean_strobe_counts: cpu=%h gfx=%h prom=%h, want 4000 1000 20", n_cpu, n_gfx, n_prom);
      end
      wait_hold(1'b0, "clean");
   endtask

   task automatic test_soft_reset();
      int t;
      int dones;
      dones = 0;
      soft_reset = 1'b1;
      tick();
      checks++;
      if (core_reset !== 1'b1) begin
         errors++;
         $display("FAIL soft_assert: core_reset=%b want 1", core_reset);
      end
      repeat (9) begin
         tick();
         if (dl_done) dones++;
      end
      soft_reset = 1'b0;
      t = 0;
      while (t < 4 * int'(H)) begin
         tick();
         t++;
         if (dl_done) dones++;
         if (core_reset === 1'b0) break;
      end
      checks++;
      if (t !== int'(H) + 1 || core_reset !== 1'b0) begin
         errors++;
         $display("FAIL soft_release_time: core_reset=%b after %0d cycles, want 0 after %0d", core_reset, t, H + 1);
      end
      repeat (3) begin
         tick();
         if (dl_done) dones++;
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL soft_no_done: dl_done seen %0d times, want 0", dones);
      end
   endtask

   task automatic test_wr_without_active();
      dl_wr = 1'b1; dl_addr = 16'h0010; dl_data = 8'h5A;
      tick();
      dl_wr = 1'b0;
      checks++;
      if ({cpu_rom_we, gfx_rom_we, prom_we} !== 3'b000 || byte_count !== 16'h5020 || core_reset !== 1'b0) begin
         errors++;
         $display("FAIL inactive_wr: we=%b cnt=%h rst=%b, want 000 5020 0",
                  {cpu_rom_we, gfx_rom_we, prom_we}, byte_count, core_reset);
      end
   endtask

   task automatic test_reset_mid_load();
      dl_active = 1'b1;
      tick();
      for (int i = 0; i <= 16'h1234; i++) begin
         dl_wr = 1'b1; dl_addr = 16'(i); dl_data = 8'(i);
         tick();
      end
      checks++;
      if (cpu_rom_we !== 1'b1 || wr_addr !== 14'h1234 || byte_count !== 16'h1235) begin
         errors++;
         $display("FAIL mid_load_progress: we=%b addr=%h cnt=%h, want 1 1234 1235", cpu_rom_we, wr_addr, byte_count);
      end
      I_RESET_n = 1'b0;
      #1;
      checks++;
      if ({cpu_rom_we, gfx_rom_we, prom_we} !== 3'b000 || core_reset !== 1'b1 || byte_count !== 16'd0) begin
         errors++;
         $display("FAIL async_abort: we=%b rst=%b cnt=%h, want 000 1 0",
                  {cpu_rom_we, gfx_rom_we, prom_we}, core_reset, byte_count);
      end
      dl_wr = 1'b0; dl_active = 1'b0;
      tick();
      I_RESET_n = 1'b1;
      repeat (5) tick();
      checks++;
      if (core_reset !== 1'b1 || byte_count !== 16'd0 || dl_done !== 1'b0) begin
         errors++;
         $display("FAIL post_abort_idle: rst=%b cnt=%h done=%b, want 1 0 0", core_reset, byte_count, dl_done);
      end
   endtask

   initial begin
      test_reset();
      test_short_load();
      test_out_of_range_and_restart();
      test_soft_reset();
      test_wr_without_active();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
